// File: rtl/if_stage_pkg.sv
// Shared core definitions: NOP encoding, PC step and the fetch-buffer entry layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instr} entries, with flush and occupancy count.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push into a full buffer is dropped unless a pop frees a slot that cycle.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: credit-limited requests, in-order responses into a fetch buffer.
// Latency: a response is presented on if_* the cycle after it returns.
// Backpressure: stall holds the head; requests stop once buffer plus in-flight reach FB_DEPTH.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(FB_DEPTH + 1);
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] kill_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [SW-1:0] in_use;
    logic [SW-1:0] kill_merge;
    logic          req_fire;
    logic          resp_ok;
    logic          resp_kill;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    fetch_entry_t  head_dat;
    fetch_entry_t  push_dat;

    assign in_use    = SW'(fifo_cnt) + SW'(live_cnt) + SW'(kill_cnt);
    assign imem_req  = !rst && !redirect && (in_use < SW'(FB_DEPTH));
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;

    // A grant this cycle already counts as outstanding, so zero-latency responses are legal.
    assign resp_ok   = imem_rvalid && !rst &&
                       ((live_cnt != '0) || (kill_cnt != '0) || req_fire);
    assign resp_kill = resp_ok && (redirect || (kill_cnt != '0));
    assign push      = resp_ok && !resp_kill;
    assign pop       = if_valid && !stall && !redirect;
    assign push_dat  = '{pc: resp_pc, instr: imem_rdata};

    // Everything still in flight at a redirect becomes a kill, less the response consumed now.
    assign kill_merge = SW'(kill_cnt) + SW'(live_cnt) + SW'(req_fire) - SW'(resp_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live_cnt <= '0;
            kill_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
            resp_pc  <= word_align(redirect_pc);
            live_cnt <= '0;
            kill_cnt <= CW'(kill_merge);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_INC;
            if (push)     resp_pc  <= resp_pc + PC_INC;
            live_cnt <= live_cnt + CW'(req_fire) - CW'(push);
            if (resp_ok && (kill_cnt != '0)) kill_cnt <= kill_cnt - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FB_DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign if_valid = !rst && !fifo_empty;
    assign if_pc    = if_valid ? head_dat.pc    : '0;
    assign if_instr = if_valid ? head_dat.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_stage.sv
// Directed and random fetch traffic against a grant-order scoreboard and a latency-modelled memory.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    if_stage #(.RESET_PC(RPC), .FB_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ready; int ep; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;

    pend_t       pend[$];
    sb_t         sb[$];
    int          sb_ret  = 0;
    int          epoch   = 0;
    int          cyc     = 0;
    int          total   = 0;
    int          bad     = 0;
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          stray   = 1'b0;
    logic [31:0] exp_addr = RPC;
    logic [31:0] held_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: memory reacts, outputs are checked, then the model advances with the edge.
    task automatic cycle();
        bit    exp_req;
        bit    exp_valid;
        bit    fire;
        bit    resp;
        pend_t p;
        sb_t   s;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        exp_req   = !rst && !redirect && (sb_ret + pend.size() < DEPTH);
        exp_valid = !rst && (sb_ret > 0);
        fire      = exp_req && imem_gnt;
        if (fire) begin
            p.addr  = exp_addr;
            p.ready = cyc + int'($urandom_range(lat_max, lat_min));
            p.ep    = epoch;
            pend.push_back(p);
            s.pc    = exp_addr;
            s.instr = instr_of(exp_addr);
            sb.push_back(s);
        end
        resp        = !rst && (pend.size() > 0) && (pend[0].ready <= cyc);
        imem_rvalid = resp || stray;
        imem_rdata  = resp ? instr_of(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
        check("req", imem_req, exp_req);
        if (exp_req) check("addr", imem_addr, exp_addr);
        check("valid", if_valid, exp_valid);
        if (exp_valid) begin
            check("pc", if_pc, sb[0].pc);
            check("instr", if_instr, sb[0].instr);
        end else begin
            check("pc_idle", if_pc, 32'h0);
            check("instr_idle", if_instr, NOP_INSTR);
        end
        if (resp) begin
            p = pend.pop_front();
            if (p.ep == epoch && !redirect) sb_ret++;
        end
        if (exp_valid && !stall && !redirect) begin
            sb.delete(0);
            sb_ret--;
        end
        if (fire) exp_addr += 32'd4;
        if (rst) begin
            pend.delete();
            sb.delete();
            sb_ret   = 0;
            epoch++;
            exp_addr = RPC;
        end else if (redirect) begin
            sb.delete();
            sb_ret   = 0;
            epoch++;
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc_exp);
        int n = 0;
        #1;
        while (!if_valid && n < 30) begin
            cycle();
            n++;
            #1;
        end
        check({tag, "_valid"}, if_valid, 1'b1);
        check(tag, if_pc, pc_exp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        repeat (3) cycle();

        // Reset release: first request at RESET_PC, then 0,4,8 back to back
        rst = 1'b0;
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RPC);
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("seq_valid", if_valid, 1'b1);
            check("seq_pc", if_pc, RPC + 32'(4 * k));
            check("seq_instr", if_instr, instr_of(RPC + 32'(4 * k)));
            cycle();
        end
        repeat (4) cycle();

        // Full buffer under a 5-cycle stall
        stall = 1'b1;
        repeat (3) cycle();
        held_pc = (sb_ret > 0) ? sb[0].pc : 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_req", imem_req, 1'b0);
            check("stall_pc", if_pc, held_pc);
            cycle();
        end
        stall = 1'b0;
        repeat (6) cycle();

        // Two outstanding at 0x10/0x14, redirect to 0x103
        redirect = 1'b1; redirect_pc = 32'h10; gnt_pct = 0;
        cycle();
        redirect = 1'b0; gnt_pct = 100; lat_min = 4; lat_max = 5;
        repeat (2) cycle();
        redirect = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect = 1'b0;
        #1;
        check("redir_addr", imem_addr, 32'h100);
        check("redir_blocked", imem_req, 1'b0);
        wait_valid("redir_first_pc", 32'h100);

        // Redirect coinciding with a grant and a response
        gnt_pct = 0;
        repeat (8) cycle();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        repeat (2) cycle();
        redirect = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0;
        #1;
        check("kill_addr", imem_addr, 32'h300);
        check("kill_nohead", if_valid, 1'b0);
        wait_valid("kill_first_pc", 32'h300);

        // Address wrap
        gnt_pct = 0;
        repeat (6) cycle();
        lat_min = 0; lat_max = 0; gnt_pct = 100;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect = 1'b0;
        cycle();
        #1;
        check("wrap_addr", imem_addr, 32'h0);
        repeat (3) cycle();

        // Back-to-back redirects
        redirect = 1'b1; redirect_pc = 32'h400;
        cycle();
        redirect_pc = 32'h500;
        cycle();
        redirect = 1'b0;
        #1;
        check("b2b_addr", imem_addr, 32'h500);
        wait_valid("b2b_pc", 32'h500);

        // Reset mid-operation with stray responses
        lat_min = 3; lat_max = 3;
        repeat (4) cycle();
        rst = 1'b1; stray = 1'b1;
        cycle();
        stray = 1'b0;
        cycle();
        rst = 1'b0; gnt_pct = 0; stray = 1'b1;
        #1;
        check("rst_req", imem_req, 1'b1);
        check("rst_addr", imem_addr, RPC);
        cycle();
        stray = 1'b0;
        #1;
        check("stray_drop", if_valid, 1'b0);
        gnt_pct = 100;
        wait_valid("rst_first_pc", RPC);

        // Random latency, grants, stalls and redirects
        lat_min = 0; lat_max = 5; gnt_pct = 60;
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(99) < 30);
            redirect    = ($urandom_range(99) < 3);
            redirect_pc = $urandom;
            cycle();
        end
        stall = 1'b0; redirect = 1'b0; gnt_pct = 100;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
